kernel_ctrl_master: RTL



---
 rtl/kernel_ctrl_master_if.sv | 33 +++
 rtl/kernel_ctrl_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kernel_ctrl_master_if.sv
// AXI4-Lite channel bundle between the kernel control initiator and the control-register slave.
interface kernel_ctrl_master_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) ();
    logic [C_M_AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic                            AWVALID;
    logic                            AWREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                            WVALID;
    logic                            WREADY;
    logic [1:0]                      BRESP;
    logic                            BVALID;
    logic                            BREADY;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic                            ARVALID;
    logic                            ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                      RRESP;
    logic                            RVALID;
    logic                            RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/kernel_ctrl_master.sv
// Kernel launch initiator: programs length/src/dst, sets the start bit, then polls the status
// register over AXI4-Lite until the done bit (bit 1) reads back set.
// Optional feature macro: CTRL_POLL_TIMEOUT_EN (abort after TIMEOUT_POLLS status reads).
module kernel_ctrl_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned POLL_GAP           = 16,
    parameter int unsigned TIMEOUT_POLLS      = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_byte_len,
    input  logic [31:0] cmd_src_addr,
    input  logic [31:0] cmd_dst_addr,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [15:0] rsp_polls,
    output logic        busy,
    kernel_ctrl_master_if.master m_axi
);
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    localparam logic [AW-1:0] AddrCtrl  = AW'(8'h10);
    localparam logic [AW-1:0] AddrLen   = AW'(8'h14);
    localparam logic [AW-1:0] AddrSrc   = AW'(8'h18);
    localparam logic [AW-1:0] AddrDst   = AW'(8'h1c);
    localparam logic [DW-1:0] StartWord = DW'(1);
    localparam logic [15:0]   GapLast   = 16'(POLL_GAP);
    localparam logic [15:0]   PollLimit = 16'(TIMEOUT_POLLS);

`ifdef CTRL_POLL_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StWr, StWrb, StGap, StRd, StRdr, StRsp} state_e;

    state_e        state_q;
    logic [1:0]    idx_q;
    logic [15:0]   gap_q;
    logic [15:0]   polls_q;
    logic [DW-1:0] src_q;
    logic [DW-1:0] dst_q;
    logic          err_q;
    logic          timeout_q;
    logic          rsp_valid_q;
    logic          cmd_ready_q;

    logic          aw_ok;
    logic          w_ok;
    logic [15:0]   polls_inc;

    // A channel counts as done once its handshake has happened, now or earlier.
    assign aw_ok     = !m_axi.AWVALID || m_axi.AWREADY;
    assign w_ok      = !m_axi.WVALID || m_axi.WREADY;
    assign polls_inc = (polls_q == 16'hFFFF) ? polls_q : polls_q + 16'd1;

    assign cmd_ready   = cmd_ready_q;
    assign busy        = (state_q != StIdle);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;  // never set when the timeout feature is compiled out
    assign rsp_polls   = polls_q;

    // Sequencer: register programming, status polling and response, all outputs registered.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            gap_q         <= 16'd0;
            polls_q       <= 16'd0;
            src_q         <= '0;
            dst_q         <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            m_axi.AWADDR  <= '0;
            m_axi.AWVALID <= 1'b0;
            m_axi.WDATA   <= '0;
            m_axi.WSTRB   <= '0;
            m_axi.WVALID  <= 1'b0;
            m_axi.BREADY  <= 1'b0;
            m_axi.ARADDR  <= '0;
            m_axi.ARVALID <= 1'b0;
            m_axi.RREADY  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready_q) begin
                        src_q         <= DW'(cmd_src_addr);
                        dst_q         <= DW'(cmd_dst_addr);
                        idx_q         <= 2'd0;
                        polls_q       <= 16'd0;
                        err_q         <= 1'b0;
                        timeout_q     <= 1'b0;
                        cmd_ready_q   <= 1'b0;
                        m_axi.AWADDR  <= AddrLen;
                        m_axi.WDATA   <= DW'(cmd_byte_len);
                        m_axi.WSTRB   <= '1;
                        m_axi.AWVALID <= 1'b1;
                        m_axi.WVALID  <= 1'b1;
                        state_q       <= StWr;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StWr: begin
                    if (m_axi.AWVALID && m_axi.AWREADY) m_axi.AWVALID <= 1'b0;
                    if (m_axi.WVALID && m_axi.WREADY) m_axi.WVALID <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi.BREADY <= 1'b1;
                        state_q      <= StWrb;
                    end
                end
                StWrb: begin
                    if (m_axi.BVALID) begin
                        m_axi.BREADY <= 1'b0;
                        if (m_axi.BRESP != 2'b00) begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else if (idx_q != 2'd3) begin
                            idx_q         <= idx_q + 2'd1;
                            m_axi.AWVALID <= 1'b1;
                            m_axi.WVALID  <= 1'b1;
                            case (idx_q)
                                2'd0:    begin m_axi.AWADDR <= AddrSrc;  m_axi.WDATA <= src_q;     end
                                2'd1:    begin m_axi.AWADDR <= AddrDst;  m_axi.WDATA <= dst_q;     end
                                default: begin m_axi.AWADDR <= AddrCtrl; m_axi.WDATA <= StartWord; end
                            endcase
                            state_q <= StWr;
                        end else if (POLL_GAP == 0) begin
                            m_axi.ARADDR  <= AddrCtrl;
                            m_axi.ARVALID <= 1'b1;
                            state_q       <= StRd;
                        end else begin
                            gap_q   <= 16'd1;
                            state_q <= StGap;
                        end
                    end
                end
                StGap: begin
                    // gap_q counts GAP cycles spent so far, starting at 1 on entry.
                    if (gap_q == GapLast) begin
                        m_axi.ARADDR  <= AddrCtrl;
                        m_axi.ARVALID <= 1'b1;
                        state_q       <= StRd;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                StRd: begin
                    if (m_axi.ARREADY) begin
                        m_axi.ARVALID <= 1'b0;
                        m_axi.RREADY  <= 1'b1;
                        state_q       <= StRdr;
                    end
                end
                StRdr: begin
                    if (m_axi.RVALID) begin
                        m_axi.RREADY <= 1'b0;
                        polls_q      <= polls_inc;
                        if (m_axi.RRESP != 2'b00) begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else if (m_axi.RDATA[1]) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else if (TimeoutEn && polls_inc == PollLimit) begin
                            err_q       <= 1'b1;
                            timeout_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StRsp;
                        end else if (POLL_GAP == 0) begin
                            m_axi.ARADDR  <= AddrCtrl;
                            m_axi.ARVALID <= 1'b1;
                            state_q       <= StRd;
                        end else begin
                            gap_q   <= 16'd1;
                            state_q <= StGap;
                        end
                    end
                end
                StRsp: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
